// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared types and constants for the GPU frame sequencing logic.
//   frame_state_t        : per-frame sequencer states (encoding is exported on
//                          state_out for debug/LEDs, so values are fixed).
//   FRAME_CYCLES_DEFAULT : default minimum clk cycles between buffer swaps.
//   IDLE_CYCLES_DEFAULT  : default consecutive idle cycles that mean "drained".
//   COUNT_W              : width of the frame/pixel count outputs.
// -----------------------------------------------------------------------------
package gpu_pkg;

    localparam int FRAME_CYCLES_DEFAULT = 2_000_000;
    localparam int IDLE_CYCLES_DEFAULT  = 4;
    localparam int COUNT_W              = 16;

    typedef enum logic [2:0] {
        WAIT_BUF = 3'd0,
        START    = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        HOLD     = 3'd4,
        SWAP     = 3'd5
    } frame_state_t;

    // Pixels are only accounted to a frame while fetch is live or draining.
    function automatic logic is_counting(input frame_state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at MAX instead of wrapping. Clear has priority over
// increment.
//   clk_in, rst_n_in : clock, asynchronous active-low reset (count -> 0)
//   clr_in           : synchronous clear to zero
//   inc_in           : increment request (ignored once count_out == MAX)
//   count_out        : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clr_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        // NOTE: default assignment first so every path assigns count_d; no latch.
        count_d = count_q;
        if (clr_in) begin
            count_d = '0;
        end else if (inc_in && (count_q != MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
// Per-frame sequencer: holds vertex_fetch in reset until the back buffer is
// ready, counts emitted pixels while fetch runs and the pipe drains, then waits
// out the minimum frame period and pulses framebuffer switch/clear.
//
// Ports
//   clk_in          : GPU clock
//   rst_n_in        : asynchronous active-low reset
//   enable_in       : allow a new frame to start (looked at only in WAIT_BUF)
//   fb_ready_in     : back buffer cleared and writable (only in WAIT_BUF)
//   fetch_done_in   : vertex_fetch has emitted its last vertex (level)
//   pipe_idle_in    : whole downstream pipe empty this cycle
//   pixel_valid_in  : fragment shader output valid
//   fetch_rst_out   : synchronous reset to vertex_fetch
//   fb_clear_out    : one-cycle clear pulse
//   fb_switch_out   : one-cycle buffer-swap pulse
//   frame_count_out : completed frames, wraps
//   pixel_count_out : pixels in last completed frame, saturating
//   overrun_out     : sticky, a frame ran past FRAME_CYCLES
//   state_out       : current frame_state_t encoding
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module frame_scheduler
    import gpu_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
    parameter int IDLE_CYCLES  = IDLE_CYCLES_DEFAULT
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               enable_in,
    input  logic               fb_ready_in,
    input  logic               fetch_done_in,
    input  logic               pipe_idle_in,
    input  logic               pixel_valid_in,
    output logic               fetch_rst_out,
    output logic               fb_clear_out,
    output logic               fb_switch_out,
    output logic [COUNT_W-1:0] frame_count_out,
    output logic [COUNT_W-1:0] pixel_count_out,
    output logic               overrun_out,
    output logic [2:0]         state_out
);

    localparam int                 TIMER_W   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(FRAME_CYCLES - 1);
    localparam int                 IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    frame_state_t state_d, state_q;

    logic               fetch_rst_d,   fetch_rst_q;
    logic               swap_pulse_d,  swap_pulse_q;
    logic [COUNT_W-1:0] frame_count_d, frame_count_q;
    logic [COUNT_W-1:0] pixel_count_d, pixel_count_q;
    logic               overrun_d,     overrun_q;

    logic [TIMER_W-1:0] timer;
    logic [IDLE_W-1:0]  idle_count;
    logic [COUNT_W-1:0] live_count;

    logic timer_full;
    logic idle_run;
    logic drained;

    assign timer_full = (timer == TIMER_MAX);
    assign idle_run   = (state_q == DRAIN) && pipe_idle_in;
    // The idle counter is registered, so "reaches IDLE_CYCLES" is detected on
    // the idle cycle that would take it there, which makes HOLD follow exactly
    // IDLE_CYCLES idle edges after DRAIN entry.
    assign drained    = idle_run && (idle_count == IDLE_LAST);

    // ---------------------------------------------------------------- counters
    // Period timer restarts on the edge into SWAP so consecutive swaps are
    // exactly FRAME_CYCLES apart when the frame itself is short.
    sat_counter #(
        .WIDTH (TIMER_W),
        .MAX   (TIMER_MAX)
    ) u_period_timer (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .clr_in    (state_d == SWAP),
        .inc_in    (1'b1),
        .count_out (timer)
    );

    // Any non-idle cycle, or leaving DRAIN, restarts the consecutive-idle run.
    sat_counter #(
        .WIDTH (IDLE_W),
        .MAX   (IDLE_MAX)
    ) u_idle_counter (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .clr_in    (!idle_run),
        .inc_in    (1'b1),
        .count_out (idle_count)
    );

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_pixel_counter (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .clr_in    (state_q == START),
        .inc_in    (is_counting(state_q) && pixel_valid_in),
        .count_out (live_count)
    );

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= WAIT_BUF;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_BUF: if (fb_ready_in && enable_in) state_d = START;
            START:    state_d = RUN;
            RUN:      if (fetch_done_in) state_d = DRAIN;
            DRAIN:    if (drained) state_d = HOLD;
            HOLD:     if (timer_full) state_d = SWAP;
            SWAP:     state_d = WAIT_BUF;
            default:  state_d = WAIT_BUF;
        endcase
    end

    // ------------------------------------------------------------ output logic
    // Outputs are computed from the state being entered so that the SWAP-cycle
    // pulses, new counts and fetch reset all appear together in that cycle.
    always_comb begin
        fetch_rst_d   = (state_d == WAIT_BUF) || (state_d == SWAP);
        swap_pulse_d  = (state_d == SWAP);
        frame_count_d = frame_count_q;
        pixel_count_d = pixel_count_q;
        overrun_d     = overrun_q;
        if (state_d == SWAP) begin
            frame_count_d = frame_count_q + COUNT_W'(1);
            // Counting stops in HOLD, so live_count is already final here.
            pixel_count_d = live_count;
        end
        if (is_counting(state_q) && timer_full) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_rst_q   <= 1'b1;
            swap_pulse_q  <= 1'b0;
            frame_count_q <= '0;
            pixel_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            fetch_rst_q   <= fetch_rst_d;
            swap_pulse_q  <= swap_pulse_d;
            frame_count_q <= frame_count_d;
            pixel_count_q <= pixel_count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign fetch_rst_out   = fetch_rst_q;
    assign fb_clear_out    = swap_pulse_q;
    assign fb_switch_out   = swap_pulse_q;
    assign frame_count_out = frame_count_q;
    assign pixel_count_out = pixel_count_q;
    assign overrun_out     = overrun_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
// Directed bench for frame_scheduler with FRAME_CYCLES=64, IDLE_CYCLES=4.
// A cycle-level reference model derived from the frame rules is compared
// against every output on each falling edge; directed steps add hand-computed
// literal expectations for the key timing points.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;
    import gpu_pkg::*;

    localparam int FC = 64;
    localparam int IC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        fb_ready = 1'b0;
    logic        fetch_done = 1'b0;
    logic        pipe_idle = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        fetch_rst;
    logic        fb_clear;
    logic        fb_switch;
    logic [15:0] frame_count;
    logic [15:0] pixel_count;
    logic        overrun;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int sw_count = 0;
    logic cmp_en = 1'b0;

    frame_scheduler #(
        .FRAME_CYCLES (FC),
        .IDLE_CYCLES  (IC)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .enable_in       (enable),
        .fb_ready_in     (fb_ready),
        .fetch_done_in   (fetch_done),
        .pipe_idle_in    (pipe_idle),
        .pixel_valid_in  (pixel_valid),
        .fetch_rst_out   (fetch_rst),
        .fb_clear_out    (fb_clear),
        .fb_switch_out   (fb_switch),
        .frame_count_out (frame_count),
        .pixel_count_out (pixel_count),
        .overrun_out     (overrun),
        .state_out       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (fb_switch === 1'b1) sw_count <= sw_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ------------------------------------------------------------ reference model
    frame_state_t m_state  = WAIT_BUF;
    int           m_timer  = 0;   // cycles since reset/swap, capped at FC-1
    int           m_idle   = 0;   // current run of consecutive idle cycles in DRAIN
    int           m_live   = 0;   // pixels so far in the current frame
    int           m_frames = 0;
    int           m_pix    = 0;
    logic         m_over   = 1'b0;

    function automatic int idle_next(frame_state_t s, int idle, logic pi);
        if (s == DRAIN && pi) return (idle + 1 > IC) ? IC : idle + 1;
        return 0;
    endfunction

    function automatic frame_state_t state_next(frame_state_t s, int timer, int idle,
                                                logic rdy, logic en, logic done, logic pi);
        case (s)
            WAIT_BUF: return (rdy && en) ? START : WAIT_BUF;
            START:    return RUN;
            RUN:      return done ? DRAIN : RUN;
            DRAIN:    return (idle_next(s, idle, pi) >= IC) ? HOLD : DRAIN;
            HOLD:     return (timer >= FC - 1) ? SWAP : HOLD;
            default:  return WAIT_BUF;
        endcase
    endfunction

    function automatic logic live_phase(frame_state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state  <= WAIT_BUF;
            m_timer  <= 0;
            m_idle   <= 0;
            m_live   <= 0;
            m_frames <= 0;
            m_pix    <= 0;
            m_over   <= 1'b0;
        end else begin
            m_idle  <= idle_next(m_state, m_idle, pipe_idle);
            m_state <= state_next(m_state, m_timer, m_idle, fb_ready, enable, fetch_done, pipe_idle);
            if (state_next(m_state, m_timer, m_idle, fb_ready, enable, fetch_done, pipe_idle) == SWAP) begin
                m_timer  <= 0;
                m_frames <= (m_frames + 1) % 65536;
                m_pix    <= m_live;
            end else begin
                m_timer <= (m_timer + 1 > FC - 1) ? FC - 1 : m_timer + 1;
            end
            if (live_phase(m_state) && m_timer == FC - 1) m_over <= 1'b1;
            if (m_state == START) m_live <= 0;
            else if (live_phase(m_state) && pixel_valid) m_live <= (m_live >= 65535) ? 65535 : m_live + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_state",       32'(state),       32'(m_state));
            check("m_fetch_rst",   32'(fetch_rst),   32'(m_state == WAIT_BUF || m_state == SWAP));
            check("m_fb_switch",   32'(fb_switch),   32'(m_state == SWAP));
            check("m_fb_clear",    32'(fb_clear),    32'(m_state == SWAP));
            check("m_frame_count", 32'(frame_count), 32'(m_frames));
            check("m_pixel_count", 32'(pixel_count), 32'(m_pix));
            check("m_overrun",     32'(overrun),     32'(m_over));
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_switch(input string name, input int budget, output int at_edge);
        at_edge = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (fb_switch === 1'b1) begin
                at_edge = edge_cnt;
                break;
            end
        end
        check({name, "_switch_seen"}, 32'(at_edge >= 0), 32'd1);
    endtask

    initial begin
        int rel, sw1, sw2, sw3, sw4, sw5, sw6, e0, swc_a;
        int pat[8]       = '{1, 1, 1, 0, 1, 1, 1, 1};
        int pat_state[8] = '{3, 3, 3, 3, 3, 3, 3, 4};

        // Reset with fb_ready and enable already high.
        fb_ready = 1'b1;
        enable   = 1'b1;
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        step(3);
        check("rst_fetch_rst", 32'(fetch_rst), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        rel   = edge_cnt;
        step(1);
        check("start_state", 32'(state), 32'd1);
        check("start_fetch_rst", 32'(fetch_rst), 32'd0);
        step(1);
        check("run_state", 32'(state), 32'd2);

        // Frame 1: 10 pixels, fetch_done at cycle 20, pipe idle afterwards.
        pixel_valid = 1'b1;
        step(10);
        pixel_valid = 1'b0;
        while (edge_cnt - rel < 20) step(1);
        fetch_done = 1'b1;
        pipe_idle  = 1'b1;
        wait_switch("f1", 100, sw1);
        check("f1_switch_edge", 32'(sw1 - rel), 32'd64);
        check("f1_clear", 32'(fb_clear), 32'd1);
        check("f1_fetch_rst", 32'(fetch_rst), 32'd1);
        check("f1_pixels", 32'(pixel_count), 32'd10);
        check("f1_frames", 32'(frame_count), 32'd1);
        check("f1_overrun", 32'(overrun), 32'd0);

        // Frame 2: idle pattern 1,1,1,0,1,1,1,1 in DRAIN.
        fetch_done = 1'b0;
        pipe_idle  = 1'b0;
        step(1);
        check("f2_wait", 32'(state), 32'd0);
        step(1);
        check("f2_start", 32'(state), 32'd1);
        fb_ready = 1'b0;
        step(1);
        fetch_done = 1'b1;
        step(1);
        check("f2_drain", 32'(state), 32'd3);
        fetch_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pipe_idle = pat[i][0];
            step(1);
            check("f2_idle_pattern", 32'(state), 32'(pat_state[i]));
        end
        wait_switch("f2", 100, sw2);
        check("f2_spacing", 32'(sw2 - sw1), 32'd64);
        check("f2_pixels", 32'(pixel_count), 32'd0);
        check("f2_frames", 32'(frame_count), 32'd2);

        // Frame 3: fetch_done withheld for 100 RUN cycles -> overrun.
        pipe_idle = 1'b0;
        fb_ready  = 1'b1;
        step(2);
        check("f3_start", 32'(state), 32'd1);
        fb_ready = 1'b0;
        step(1);
        for (int i = 0; i < 100; i++) begin
            pixel_valid = (i < 5);
            step(1);
        end
        pixel_valid = 1'b0;
        fetch_done  = 1'b1;
        pipe_idle   = 1'b1;
        e0 = edge_cnt;
        wait_switch("f3", 100, sw3);
        check("f3_swap_delay", 32'(sw3 - e0), 32'(IC + 2));
        check("f3_overrun", 32'(overrun), 32'd1);
        check("f3_pixels", 32'(pixel_count), 32'd5);
        check("f3_frames", 32'(frame_count), 32'd3);

        // Frame 4: shortest frame right after the overrun one.
        fetch_done = 1'b0;
        pipe_idle  = 1'b0;
        fb_ready   = 1'b1;
        step(2);
        fb_ready   = 1'b0;
        fetch_done = 1'b1;
        pipe_idle  = 1'b1;
        wait_switch("f4", 200, sw4);
        check("f4_spacing", 32'(sw4 - sw3), 32'd64);
        check("f4_overrun_sticky", 32'(overrun), 32'd1);
        check("f4_frames", 32'(frame_count), 32'd4);

        // Frame 5: more pixels than fit in 16 bits.
        fetch_done = 1'b0;
        pipe_idle  = 1'b0;
        fb_ready   = 1'b1;
        step(2);
        fb_ready = 1'b0;
        step(1);
        pixel_valid = 1'b1;
        step(65600);
        pixel_valid = 1'b0;
        fetch_done  = 1'b1;
        pipe_idle   = 1'b1;
        wait_switch("f5", 200, sw5);
        check("f5_pixels_sat", 32'(pixel_count), 32'h0000_FFFF);
        check("f5_frames", 32'(frame_count), 32'd5);

        // Frame 6: enable dropped mid-RUN, fb_ready left high.
        fetch_done = 1'b0;
        pipe_idle  = 1'b0;
        fb_ready   = 1'b1;
        step(2);
        check("f6_start", 32'(state), 32'd1);
        step(1);
        check("f6_run", 32'(state), 32'd2);
        enable = 1'b0;
        swc_a  = sw_count;
        pixel_valid = 1'b1;
        step(3);
        pixel_valid = 1'b0;
        fetch_done  = 1'b1;
        pipe_idle   = 1'b1;
        wait_switch("f6", 200, sw6);
        check("f6_pixels", 32'(pixel_count), 32'd3);
        fetch_done = 1'b0;
        pipe_idle  = 1'b0;
        step(100);
        check("f6_one_pulse", 32'(sw_count - swc_a), 32'd1);
        check("f6_parked_state", 32'(state), 32'd0);
        check("f6_parked_fetch_rst", 32'(fetch_rst), 32'd1);

        // Frame 7: async reset while in DRAIN, checked before any clock edge.
        enable = 1'b1;
        step(1);
        check("f7_start", 32'(state), 32'd1);
        fb_ready = 1'b0;
        step(1);
        fetch_done = 1'b1;
        step(1);
        check("f7_drain", 32'(state), 32'd3);
        fetch_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_fetch_rst", 32'(fetch_rst), 32'd1);
        check("ar_switch", 32'(fb_switch), 32'd0);
        check("ar_clear", 32'(fb_clear), 32'd0);
        check("ar_frames", 32'(frame_count), 32'd0);
        check("ar_pixels", 32'(pixel_count), 32'd0);
        check("ar_overrun", 32'(overrun), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(5);
        check("post_reset_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
